// File: rtl/enemy_bomb.sv
// enemy_bomb: an enemy projectile that falls down the screen and reports a hit on the player ship.
//
// Ports:
//   s_clk         pixel/system clock, the only clock
//   rst           synchronous, active-high reset
//   move_tick     one-cycle motion enable, once per frame or slower
//   fire          launch request; ignored while busy
//   orig_x/orig_y launch position (top-left of bomb), sampled on an accepted fire
//   pixel_x/y     current scan position
//   player_pixel  scan position is on the player ship
//   bomb_pixel    scan position is on the falling bomb (combinational)
//   busy          bomb in flight or exploding
//   player_hit    one-cycle pulse on the cycle after a collision
//   bomb_x/bomb_y current registered bomb position
module enemy_bomb #(
    parameter int unsigned BOMB_W        = 4,
    parameter int unsigned BOMB_H        = 12,
    parameter int unsigned STEP          = 2,
    parameter int unsigned SCREEN_H      = 480,
    parameter int unsigned EXPLODE_TICKS = 30
) (
    input  logic        s_clk,
    input  logic        rst,
    input  logic        move_tick,
    input  logic        fire,
    input  logic [10:0] orig_x,
    input  logic [10:0] orig_y,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        player_pixel,
    output logic        bomb_pixel,
    output logic        busy,
    output logic        player_hit,
    output logic [10:0] bomb_x,
    output logic [10:0] bomb_y
);

    localparam int unsigned CntW = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;

    // 12-bit constants so position sums never wrap.
    localparam logic [11:0] StepExt  = 12'(STEP);
    localparam logic [11:0] LimitExt = 12'(SCREEN_H - BOMB_H);
    localparam logic [11:0] WExt     = 12'(BOMB_W);
    localparam logic [11:0] HExt     = 12'(BOMB_H);
    localparam logic [CntW-1:0] CntLast = CntW'(EXPLODE_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StFly, StHit} state_e;

    state_e          state_q, state_d;
    logic [10:0]     bomb_x_q, bomb_x_d;
    logic [10:0]     bomb_y_q, bomb_y_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            hit_q, hit_d;

    logic [11:0]     bx_ext, by_ext, px_ext, py_ext, next_y;
    logic            collide;

    assign bx_ext  = {1'b0, bomb_x_q};
    assign by_ext  = {1'b0, bomb_y_q};
    assign px_ext  = {1'b0, pixel_x};
    assign py_ext  = {1'b0, pixel_y};
    assign next_y  = by_ext + StepExt;
    assign collide = bomb_pixel & player_pixel;

    // State register
    always_ff @(posedge s_clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge s_clk) begin
        if (rst) begin
            bomb_x_q <= '0;
            bomb_y_q <= '0;
            cnt_q    <= '0;
            hit_q    <= 1'b0;
        end else begin
            bomb_x_q <= bomb_x_d;
            bomb_y_q <= bomb_y_d;
            cnt_q    <= cnt_d;
            hit_q    <= hit_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        bomb_x_d = bomb_x_q;
        bomb_y_d = bomb_y_q;
        cnt_d    = cnt_q;
        hit_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fire) begin
                    bomb_x_d = orig_x;
                    bomb_y_d = orig_y;
                    state_d  = StFly;
                end
            end
            StFly: begin
                // A collision wins over a coincident move_tick; position stays put.
                if (collide) begin
                    state_d = StHit;
                    hit_d   = 1'b1;
                    cnt_d   = '0;
                end else if (move_tick) begin
                    if (next_y > LimitExt) begin
                        state_d = StIdle;
                    end else begin
                        bomb_y_d = next_y[10:0];
                    end
                end
            end
            StHit: begin
                if (move_tick) begin
                    if (cnt_q == CntLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy       = (state_q != StIdle);
        bomb_pixel = (state_q == StFly) &&
                     (px_ext >= bx_ext) && (px_ext < bx_ext + WExt) &&
                     (py_ext >= by_ext) && (py_ext < by_ext + HExt);
    end

    assign player_hit = hit_q;
    assign bomb_x     = bomb_x_q;
    assign bomb_y     = bomb_y_q;

endmodule

// File: tb/tb_enemy_bomb.sv
module tb_enemy_bomb;

    logic        s_clk = 1'b0;
    logic        rst, move_tick, fire, player_pixel;
    logic [10:0] orig_x, orig_y, pixel_x, pixel_y;
    logic        bomb_pixel, busy, player_hit;
    logic [10:0] bomb_x, bomb_y;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard queues: filled when stimulus is driven, drained after the DUT edge.
    logic [10:0] exp_y_q[$];
    logic        exp_busy_q[$];

    enemy_bomb #(
        .BOMB_W       (4),
        .BOMB_H       (12),
        .STEP         (2),
        .SCREEN_H     (480),
        .EXPLODE_TICKS(4)
    ) dut (
        .s_clk       (s_clk),
        .rst         (rst),
        .move_tick   (move_tick),
        .fire        (fire),
        .orig_x      (orig_x),
        .orig_y      (orig_y),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .player_pixel(player_pixel),
        .bomb_pixel  (bomb_pixel),
        .busy        (busy),
        .player_hit  (player_hit),
        .bomb_x      (bomb_x),
        .bomb_y      (bomb_y)
    );

    always #5 s_clk = ~s_clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge s_clk);
        #1;
    endtask

    task automatic clear_inputs();
        move_tick    = 1'b0;
        fire         = 1'b0;
        player_pixel = 1'b0;
        orig_x       = '0;
        orig_y       = '0;
        pixel_x      = '0;
        pixel_y      = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic launch(input logic [10:0] x, input logic [10:0] y);
        fire   = 1'b1;
        orig_x = x;
        orig_y = y;
        cyc();
        fire = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        n_tests++;
        if ({bomb_pixel, busy, player_hit, bomb_x, bomb_y} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_state: got pix=%b busy=%b hit=%b x=%0d y=%0d required all 0",
                     bomb_pixel, busy, player_hit, bomb_x, bomb_y);
        end
        for (int i = 0; i < 10; i++) begin
            move_tick = ~move_tick;
            cyc();
            n_tests++;
            if ({bomb_pixel, busy, player_hit, bomb_x, bomb_y} !== 25'd0) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: got pix=%b busy=%b hit=%b x=%0d y=%0d required 0",
                         i, bomb_pixel, busy, player_hit, bomb_x, bomb_y);
            end
        end
        move_tick = 1'b0;
    endtask

    task automatic test_launch_fall();
        logic [10:0] y_model;
        int px[4] = '{100, 103, 104, 100};
        int py[4] = '{60, 71, 60, 72};
        logic ep[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        launch(11'd100, 11'd50);
        n_tests++;
        if ({busy, bomb_x, bomb_y} !== {1'b1, 11'd100, 11'd50}) begin
            n_fail++;
            $display("FAIL launch_latch: got busy=%b x=%0d y=%0d required 1,100,50",
                     busy, bomb_x, bomb_y);
        end
        pixel_x = 11'd100;
        pixel_y = 11'd50;
        #1;
        n_tests++;
        if (bomb_pixel !== 1'b1) begin
            n_fail++;
            $display("FAIL launch_first_pixel: got %b required 1", bomb_pixel);
        end
        pixel_x = '0;
        pixel_y = '0;
        y_model = 11'd50;
        for (int i = 0; i < 5; i++) begin
            move_tick = 1'b1;
            y_model   = y_model + 11'd2;
            exp_y_q.push_back(y_model);
            cyc();
            move_tick = 1'b0;
            n_tests++;
            if (bomb_y !== exp_y_q.pop_front() || busy !== 1'b1 || player_hit !== 1'b0) begin
                n_fail++;
                $display("FAIL fall_step[%0d]: got y=%0d busy=%b hit=%b required y=%0d busy=1 hit=0",
                         i, bomb_y, busy, player_hit, y_model);
            end
        end
        for (int i = 0; i < 4; i++) begin
            pixel_x = 11'(px[i]);
            pixel_y = 11'(py[i]);
            #1;
            n_tests++;
            if (bomb_pixel !== ep[i]) begin
                n_fail++;
                $display("FAIL pixel_window(%0d,%0d): got %b required %b",
                         px[i], py[i], bomb_pixel, ep[i]);
            end
        end
    endtask

    task automatic test_offscreen();
        logic [11:0] y_model;
        logic        fly;
        int          ticks;
        do_reset();
        launch(11'd10, 11'd464);
        y_model = 12'd464;
        fly     = 1'b1;
        ticks   = 0;
        while (fly && ticks < 20) begin
            move_tick = 1'b1;
            if (y_model + 12'd2 > 12'd468) fly = 1'b0;
            else y_model = y_model + 12'd2;
            exp_busy_q.push_back(fly);
            exp_y_q.push_back(y_model[10:0]);
            cyc();
            move_tick = 1'b0;
            ticks++;
            n_tests++;
            if (busy !== exp_busy_q.pop_front() || player_hit !== 1'b0 ||
                (fly && bomb_y !== exp_y_q[0])) begin
                n_fail++;
                $display("FAIL offscreen_tick[%0d]: got busy=%b hit=%b y=%0d required busy=%b hit=0 y=%0d",
                         ticks, busy, player_hit, bomb_y, fly, y_model);
            end
            void'(exp_y_q.pop_front());
        end
        launch(11'd20, 11'd30);
        n_tests++;
        if ({busy, bomb_x, bomb_y} !== {1'b1, 11'd20, 11'd30}) begin
            n_fail++;
            $display("FAIL relaunch_after_retire: got busy=%b x=%0d y=%0d required 1,20,30",
                     busy, bomb_x, bomb_y);
        end
        do_reset();
        launch(11'd5, 11'd470);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL low_launch_accept: got busy=%b required 1", busy);
        end
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || player_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL low_launch_retire: got busy=%b hit=%b required 0,0", busy, player_hit);
        end
    endtask

    task automatic test_hit();
        do_reset();
        launch(11'd200, 11'd400);
        pixel_x      = 11'd201;
        pixel_y      = 11'd405;
        player_pixel = 1'b1;
        cyc();
        n_tests++;
        if ({player_hit, busy, bomb_pixel, bomb_x, bomb_y} !== {3'b110, 11'd200, 11'd400}) begin
            n_fail++;
            $display("FAIL hit_pulse: got hit=%b busy=%b pix=%b x=%0d y=%0d required 1,1,0,200,400",
                     player_hit, busy, bomb_pixel, bomb_x, bomb_y);
        end
        fire   = 1'b1;
        orig_x = 11'd7;
        orig_y = 11'd9;
        cyc();
        fire = 1'b0;
        n_tests++;
        if ({player_hit, busy, bomb_x, bomb_y} !== {2'b01, 11'd200, 11'd400}) begin
            n_fail++;
            $display("FAIL hit_single_and_fire_ignored: got hit=%b busy=%b x=%0d y=%0d required 0,1,200,400",
                     player_hit, busy, bomb_x, bomb_y);
        end
        for (int i = 1; i <= 4; i++) begin
            move_tick = 1'b1;
            exp_busy_q.push_back(i < 4);
            cyc();
            move_tick = 1'b0;
            n_tests++;
            if (busy !== exp_busy_q[0] || player_hit !== 1'b0 || bomb_pixel !== 1'b0) begin
                n_fail++;
                $display("FAIL explode_tick[%0d]: got busy=%b hit=%b pix=%b required busy=%b hit=0 pix=0",
                         i, busy, player_hit, bomb_pixel, exp_busy_q[0]);
            end
            void'(exp_busy_q.pop_front());
        end
        player_pixel = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        launch(11'd300, 11'd100);
        fire   = 1'b1;
        orig_x = 11'd1;
        orig_y = 11'd1;
        cyc();
        fire = 1'b0;
        n_tests++;
        if ({busy, bomb_x, bomb_y} !== {1'b1, 11'd300, 11'd100}) begin
            n_fail++;
            $display("FAIL fire_during_fly: got busy=%b x=%0d y=%0d required 1,300,100",
                     busy, bomb_x, bomb_y);
        end
        pixel_x      = 11'd300;
        pixel_y      = 11'd100;
        player_pixel = 1'b1;
        move_tick    = 1'b1;
        cyc();
        move_tick    = 1'b0;
        player_pixel = 1'b0;
        n_tests++;
        if ({player_hit, busy, bomb_pixel, bomb_y} !== {3'b110, 11'd100}) begin
            n_fail++;
            $display("FAIL collide_beats_tick: got hit=%b busy=%b pix=%b y=%0d required 1,1,0,100",
                     player_hit, busy, bomb_pixel, bomb_y);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        launch(11'd50, 11'd50);
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
        rst    = 1'b1;
        fire   = 1'b1;
        orig_x = 11'd7;
        orig_y = 11'd7;
        cyc();
        rst  = 1'b0;
        fire = 1'b0;
        n_tests++;
        if ({busy, player_hit, bomb_x, bomb_y} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_in_fly: got busy=%b hit=%b x=%0d y=%0d required 0",
                     busy, player_hit, bomb_x, bomb_y);
        end
        launch(11'd60, 11'd60);
        pixel_x      = 11'd60;
        pixel_y      = 11'd60;
        player_pixel = 1'b1;
        rst          = 1'b1;
        cyc();
        rst = 1'b0;
        n_tests++;
        if ({busy, player_hit} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_beats_collide: got busy=%b hit=%b required 0,0", busy, player_hit);
        end
        launch(11'd60, 11'd60);
        cyc();
        n_tests++;
        if ({busy, player_hit} !== 2'b11) begin
            n_fail++;
            $display("FAIL enter_hit: got busy=%b hit=%b required 1,1", busy, player_hit);
        end
        rst = 1'b1;
        cyc();
        rst          = 1'b0;
        player_pixel = 1'b0;
        n_tests++;
        if ({busy, player_hit, bomb_x, bomb_y} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_in_hit: got busy=%b hit=%b x=%0d y=%0d required 0",
                     busy, player_hit, bomb_x, bomb_y);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_launch_fall();
        test_offscreen();
        test_hit();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule
